// File: rtl/apsk_frame_sequencer.sv
// apsk_frame_sequencer
//   Frame scheduler in front of the APSK modulator data input. It interleaves
//   a header stream and a payload stream into one AXI-Stream. Each segment is
//   closed with tlast, and mod_bits_per_symbol is set for each segment. The next
//   segment is held back until the modulator reports that the previous one has
//   flushed (mod_frame_done).
//
//   Optional feature macro: APSK_FRAME_SEQUENCER_PILOT_EN
//     When this macro is defined, a pilot segment of PILOT_WORDS x PILOT_PATTERN is
//     sent at header bps after the payload, and it is waited on before the frame
//     counts as complete.
//
//   Ports
//     aclk, aresetn                         clock, synchronous active-low reset
//     hdr_in_*   (tvalid/tready/tdata)      header source stream
//     pld_in_*   (tvalid/tready/tdata)      payload source stream
//     cfg_enable                            permit starting new frames
//     cfg_hdr_bps, cfg_pld_bps              bits per symbol, legal 1..8
//     cfg_hdr_words, cfg_pld_words          segment lengths in words, non-zero
//     mod_data_* (tvalid/tready/tdata/tlast) stream to the modulator
//     mod_bits_per_symbol                   modulator constellation select
//     mod_frame_done                        modulator segment-flushed pulse
//     busy                                  high outside IDLE
//     cfg_error                             sticky illegal-config flag
//     frame_count                           completed frames, wraps
module apsk_frame_sequencer #(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           COUNT_WIDTH   = 16,
  parameter int unsigned           PILOT_WORDS   = 2,
  parameter logic [DATA_WIDTH-1:0] PILOT_PATTERN = DATA_WIDTH'(32'h0000_0000)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  output logic                   hdr_in_tready,
  input  logic                   hdr_in_tvalid,
  input  logic [DATA_WIDTH-1:0]  hdr_in_tdata,
  output logic                   pld_in_tready,
  input  logic                   pld_in_tvalid,
  input  logic [DATA_WIDTH-1:0]  pld_in_tdata,
  input  logic                   cfg_enable,
  input  logic [3:0]             cfg_hdr_bps,
  input  logic [3:0]             cfg_pld_bps,
  input  logic [COUNT_WIDTH-1:0] cfg_hdr_words,
  input  logic [COUNT_WIDTH-1:0] cfg_pld_words,
  input  logic                   mod_data_tready,
  output logic                   mod_data_tvalid,
  output logic [DATA_WIDTH-1:0]  mod_data_tdata,
  output logic                   mod_data_tlast,
  output logic [3:0]             mod_bits_per_symbol,
  input  logic                   mod_frame_done,
  output logic                   busy,
  output logic                   cfg_error,
  output logic [COUNT_WIDTH-1:0] frame_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HDR_WAIT,
    ST_PLD,
    ST_PLD_WAIT
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
    ,
    ST_PILOT,
    ST_PILOT_WAIT
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]             bps_q, bps_d;
  logic                   err_q, err_d;
  logic [COUNT_WIDTH-1:0] fc_q, fc_d;
  logic [3:0]             hdr_bps_q, hdr_bps_d;
  logic [3:0]             pld_bps_q, pld_bps_d;
  logic [COUNT_WIDTH-1:0] hdr_words_q, hdr_words_d;
  logic [COUNT_WIDTH-1:0] pld_words_q, pld_words_d;

  logic cfg_legal;
  logic hdr_last, pld_last;
  logic beat;

  assign cfg_legal = (cfg_hdr_bps != 4'd0) && (cfg_hdr_bps <= 4'd8) &&
                     (cfg_pld_bps != 4'd0) && (cfg_pld_bps <= 4'd8) &&
                     (cfg_hdr_words != '0) && (cfg_pld_words != '0);

  assign hdr_last = (cnt_q == (hdr_words_q - COUNT_WIDTH'(1)));
  assign pld_last = (cnt_q == (pld_words_q - COUNT_WIDTH'(1)));

`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
  logic pilot_last;
  assign pilot_last = (cnt_q == COUNT_WIDTH'(PILOT_WORDS - 1));
`else
  logic unused_pilot;
  assign unused_pilot = (^PILOT_PATTERN) ^ (PILOT_WORDS != 0);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bps_d       = bps_q;
    err_d       = err_q;
    fc_d        = fc_q;
    hdr_bps_d   = hdr_bps_q;
    pld_bps_d   = pld_bps_q;
    hdr_words_d = hdr_words_q;
    pld_words_d = pld_words_q;

    hdr_in_tready   = 1'b0;
    pld_in_tready   = 1'b0;
    mod_data_tvalid = 1'b0;
    mod_data_tdata  = '0;
    mod_data_tlast  = 1'b0;

    // Zero-latency datapath mux: the selected source drives the modulator directly.
    case (state_q)
      ST_HDR: begin
        mod_data_tvalid = hdr_in_tvalid;
        mod_data_tdata  = hdr_in_tdata;
        mod_data_tlast  = hdr_last;
        hdr_in_tready   = mod_data_tready;
      end
      ST_PLD: begin
        mod_data_tvalid = pld_in_tvalid;
        mod_data_tdata  = pld_in_tdata;
        mod_data_tlast  = pld_last;
        pld_in_tready   = mod_data_tready;
      end
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
      ST_PILOT: begin
        mod_data_tvalid = 1'b1;
        mod_data_tdata  = PILOT_PATTERN;
        mod_data_tlast  = pilot_last;
      end
`endif
      default: ;
    endcase

    beat = mod_data_tvalid & mod_data_tready;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          if (cfg_legal) begin
            state_d     = ST_HDR;
            hdr_bps_d   = cfg_hdr_bps;
            pld_bps_d   = cfg_pld_bps;
            hdr_words_d = cfg_hdr_words;
            pld_words_d = cfg_pld_words;
            bps_d       = cfg_hdr_bps;
            cnt_d       = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (beat) begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
          if (hdr_last) state_d = ST_HDR_WAIT;
        end
      end
      ST_HDR_WAIT: begin
        if (mod_frame_done) begin
          bps_d   = pld_bps_q;
          cnt_d   = '0;
          state_d = ST_PLD;
        end
      end
      ST_PLD: begin
        if (beat) begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
          if (pld_last) state_d = ST_PLD_WAIT;
        end
      end
      ST_PLD_WAIT: begin
        if (mod_frame_done) begin
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
          bps_d   = hdr_bps_q;
          cnt_d   = '0;
          state_d = ST_PILOT;
`else
          fc_d    = fc_q + COUNT_WIDTH'(1);
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
      ST_PILOT: begin
        if (beat) begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
          if (pilot_last) state_d = ST_PILOT_WAIT;
        end
      end
      ST_PILOT_WAIT: begin
        if (mod_frame_done) begin
          fc_d    = fc_q + COUNT_WIDTH'(1);
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bps_q       <= 4'd1;
      err_q       <= 1'b0;
      fc_q        <= '0;
      hdr_bps_q   <= '0;
      pld_bps_q   <= '0;
      hdr_words_q <= '0;
      pld_words_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bps_q       <= bps_d;
      err_q       <= err_d;
      fc_q        <= fc_d;
      hdr_bps_q   <= hdr_bps_d;
      pld_bps_q   <= pld_bps_d;
      hdr_words_q <= hdr_words_d;
      pld_words_q <= pld_words_d;
    end
  end

  assign mod_bits_per_symbol = bps_q;
  assign busy                = (state_q != ST_IDLE);
  assign cfg_error           = err_q;
  assign frame_count         = fc_q;

endmodule

// File: tb/tb_apsk_frame_sequencer.sv
module tb_apsk_frame_sequencer;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int PW = 2;
  localparam logic [DW-1:0] PPAT = 32'hA5A5A5A5;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          hdr_in_tready, hdr_in_tvalid;
  logic [DW-1:0] hdr_in_tdata;
  logic          pld_in_tready, pld_in_tvalid;
  logic [DW-1:0] pld_in_tdata;
  logic          cfg_enable;
  logic [3:0]    cfg_hdr_bps, cfg_pld_bps;
  logic [CW-1:0] cfg_hdr_words, cfg_pld_words;
  logic          mod_data_tready, mod_data_tvalid, mod_data_tlast;
  logic [DW-1:0] mod_data_tdata;
  logic [3:0]    mod_bits_per_symbol;
  logic          mod_frame_done, busy, cfg_error;
  logic [CW-1:0] frame_count;

  always #5 aclk = ~aclk;

  apsk_frame_sequencer #(
    .DATA_WIDTH(DW),
    .COUNT_WIDTH(CW),
    .PILOT_WORDS(PW),
    .PILOT_PATTERN(PPAT)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .hdr_in_tready(hdr_in_tready),
    .hdr_in_tvalid(hdr_in_tvalid),
    .hdr_in_tdata(hdr_in_tdata),
    .pld_in_tready(pld_in_tready),
    .pld_in_tvalid(pld_in_tvalid),
    .pld_in_tdata(pld_in_tdata),
    .cfg_enable(cfg_enable),
    .cfg_hdr_bps(cfg_hdr_bps),
    .cfg_pld_bps(cfg_pld_bps),
    .cfg_hdr_words(cfg_hdr_words),
    .cfg_pld_words(cfg_pld_words),
    .mod_data_tready(mod_data_tready),
    .mod_data_tvalid(mod_data_tvalid),
    .mod_data_tdata(mod_data_tdata),
    .mod_data_tlast(mod_data_tlast),
    .mod_bits_per_symbol(mod_bits_per_symbol),
    .mod_frame_done(mod_frame_done),
    .busy(busy),
    .cfg_error(cfg_error),
    .frame_count(frame_count)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [3:0]    b;
  } beat_t;

  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_fc = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    hdr_in_tvalid   = 1'b0;
    hdr_in_tdata    = '0;
    pld_in_tvalid   = 1'b0;
    pld_in_tdata    = '0;
    cfg_enable      = 1'b0;
    mod_data_tready = 1'b0;
    mod_frame_done  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    exp_fc = '0;
  endtask

  // Frame model: the expected beat list is the header words, then the payload
  // words, then (pilot build) the pilot words; each tagged with its segment's bps
  // and with tlast on its final word. The modulator is emulated with a done
  // pulse 10 cycles after every accepted tlast.
  task automatic run_frame(input logic [3:0] hb, input logic [CW-1:0] hw,
                           input logic [3:0] pb, input logic [CW-1:0] pw,
                           input bit rnd, input int rst_pw);
    logic [DW-1:0] hq[$];
    logic [DW-1:0] pq[$];
    beat_t expq[$];
    beat_t obs[$];
    beat_t e;
    logic [3:0] seg_bps[3];
    logic [3:0] nb = '0;
    int nseg, n;
    int hidx = 0, pidx = 0, dcnt = 0, seg = 0;
    bit hhold = 0, phold = 0, waiting, real_done, pend = 0, expect_end = 0, finished = 0;

    for (int i = 0; i < int'(hw); i++) begin
      hq.push_back(DW'($urandom));
      e.d = hq[i]; e.l = (i == int'(hw) - 1); e.b = hb;
      expq.push_back(e);
    end
    for (int i = 0; i < int'(pw); i++) begin
      pq.push_back(DW'($urandom));
      e.d = pq[i]; e.l = (i == int'(pw) - 1); e.b = pb;
      expq.push_back(e);
    end
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
    for (int i = 0; i < PW; i++) begin
      e.d = PPAT; e.l = (i == PW - 1); e.b = hb;
      expq.push_back(e);
    end
    nseg = 3;
`else
    nseg = 2;
`endif
    seg_bps[0] = hb;
    seg_bps[1] = pb;
    seg_bps[2] = hb;

    cfg_hdr_bps   = hb;
    cfg_pld_bps   = pb;
    cfg_hdr_words = hw;
    cfg_pld_words = pw;
    cfg_enable    = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) begin
        // Config is scrambled after the start to show it is shadowed.
        cfg_enable    = 1'b0;
        cfg_hdr_bps   = 4'($urandom);
        cfg_pld_bps   = 4'($urandom);
        cfg_hdr_words = CW'($urandom);
        cfg_pld_words = CW'($urandom);
      end
      waiting   = (dcnt > 0);
      real_done = (dcnt == 1);
      if (dcnt > 0) dcnt--;
      mod_frame_done = real_done || (rnd && !waiting && $urandom_range(0, 6) == 0);

      if (hidx < int'(hw)) begin
        hhold = hhold || !rnd || ($urandom_range(0, 1) == 1);
        hdr_in_tvalid = hhold;
        hdr_in_tdata  = hhold ? hq[hidx] : DW'($urandom);
      end else begin
        hdr_in_tvalid = 1'b0;
        hdr_in_tdata  = DW'($urandom);
      end
      if (pidx < int'(pw)) begin
        phold = phold || !rnd || ($urandom_range(0, 1) == 1);
        pld_in_tvalid = phold;
        pld_in_tdata  = phold ? pq[pidx] : DW'($urandom);
      end else begin
        pld_in_tvalid = 1'b0;
        pld_in_tdata  = DW'($urandom);
      end
      mod_data_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      aresetn = !(rst_pw > 0 && seg == 1 && !waiting && pidx == rst_pw - 1);
      #1;

      if (!aresetn) begin
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_fc = '0;
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_tvalid", 64'(mod_data_tvalid), 64'(0));
        chk("rst_mid_cfg_error", 64'(cfg_error), 64'(0));
        chk("rst_mid_frame_count", 64'(frame_count), 64'(exp_fc));
        chk("rst_mid_bps", 64'(mod_bits_per_symbol), 64'(1));
        idle_inputs();
        return;
      end

      if (expect_end) begin
        chk("frame_count", 64'(frame_count), 64'(exp_fc));
        chk("busy_after_frame", 64'(busy), 64'(0));
        finished = 1;
        break;
      end
      if (pend) begin
        chk("bps_after_done", 64'(mod_bits_per_symbol), 64'(nb));
        pend = 0;
      end
      if (waiting)
        chk("wait_quiet", 64'({mod_data_tvalid, hdr_in_tready, pld_in_tready}), 64'(0));

      if (mod_data_tvalid && mod_data_tready) begin
        e.d = mod_data_tdata; e.l = mod_data_tlast; e.b = mod_bits_per_symbol;
        obs.push_back(e);
        if (mod_data_tlast) dcnt = 10;
      end
      if (hdr_in_tvalid && hdr_in_tready) begin hidx++; hhold = 0; end
      if (pld_in_tvalid && pld_in_tready) begin pidx++; phold = 0; end

      if (real_done) begin
        chk("bps_at_done", 64'(mod_bits_per_symbol), 64'(seg_bps[seg]));
        seg++;
        if (seg == nseg) begin
          expect_end = 1;
          exp_fc = exp_fc + CW'(1);
        end else begin
          pend = 1;
          nb = seg_bps[seg];
        end
      end
      @(posedge aclk);
      #1;
    end
    idle_inputs();
    chk("frame_complete", 64'(finished), 64'(1));
    chk("beat_count", 64'(obs.size()), 64'(expq.size()));
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("beat[%0d]", i), 64'(obs[i]), 64'(expq[i]));
  endtask

  task automatic illegal(input string tag, input logic [3:0] hb, input logic [CW-1:0] hw,
                         input logic [3:0] pb, input logic [CW-1:0] pw);
    cfg_hdr_bps     = hb;
    cfg_pld_bps     = pb;
    cfg_hdr_words   = hw;
    cfg_pld_words   = pw;
    cfg_enable      = 1'b1;
    mod_data_tready = 1'b1;
    hdr_in_tvalid   = 1'b1;
    pld_in_tvalid   = 1'b1;
    @(posedge aclk);
    #1;
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_cfg_error"}, 64'(cfg_error), 64'(1));
    chk({tag, "_treadys"}, 64'({hdr_in_tready, pld_in_tready, mod_data_tvalid}), 64'(0));
    idle_inputs();
    @(posedge aclk);
    #1;
    chk({tag, "_sticky"}, 64'(cfg_error), 64'(1));
  endtask

  initial begin
    cfg_hdr_bps = '0; cfg_pld_bps = '0; cfg_hdr_words = '0; cfg_pld_words = '0;
    do_reset();
    chk("rst_bps", 64'(mod_bits_per_symbol), 64'(1));
    chk("rst_tvalid", 64'(mod_data_tvalid), 64'(0));
    chk("rst_tlast", 64'(mod_data_tlast), 64'(0));
    chk("rst_hdr_tready", 64'(hdr_in_tready), 64'(0));
    chk("rst_pld_tready", 64'(pld_in_tready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cfg_error", 64'(cfg_error), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));

    illegal("ill_pld_bps9", 4'd1, CW'(3), 4'd9, CW'(5));
    do_reset();
    chk("cfg_error_cleared", 64'(cfg_error), 64'(0));

    run_frame(4'd1, CW'(3), 4'd3, CW'(5), 1'b0, 0);
    run_frame(4'd1, CW'(3), 4'd3, CW'(5), 1'b1, 0);
    run_frame(4'd8, CW'(1), 4'd8, CW'(1), 1'b1, 0);
    run_frame(4'd1, CW'(1), 4'd8, CW'(2), 1'b1, 0);
    for (int k = 0; k < 4; k++)
      run_frame(4'($urandom_range(1, 8)), CW'($urandom_range(1, 12)),
                4'($urandom_range(1, 8)), CW'($urandom_range(1, 12)), 1'b1, 0);

    illegal("ill_hdr_words0", 4'd2, CW'(0), 4'd2, CW'(4));
    illegal("ill_hdr_bps0", 4'd0, CW'(2), 4'd2, CW'(4));

    run_frame(4'd2, CW'(3), 4'd4, CW'(5), 1'b0, 2);
    run_frame(4'd6, CW'(2), 4'd2, CW'(4), 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
